pic_bus_interface: RTL
======================

Name: pic_bus_interface

Overview:
Parametrised next-generation bus front end for the 8259A-style PIC. It synchronises the CPU strobes and latches the data bus. It detects completed writes and tracks the ICW1→ICW2→[ICW3]→[ICW4] initialization sequence in a state machine, emitting exactly one registered command strobe per accepted write. It also holds the OCW3 read-register selection and drives the read path select for the data-bus output mux.

Parameters:
DATA_WIDTH, 8, width of data bus and internal latch; must be ≥ 8, and only bits [7:0] are decoded.
SYNC_STAGES, 2, flip-flop stages on CS/RD/WR/address; 0 means sampled directly.

Ports:
clock  in  1  system clock; all state updates on the falling edge
reset  in  1  asynchronous, active-high reset
CS  in  1  chip select, active low
RD  in  1  read enable, active low
WR  in  1  write enable, active low
address  in  1  A0
data_bus_in  in  DATA_WIDTH  CPU write data
internal_data_bus  out  DATA_WIDTH  latched write data
write_icw1 / write_icw2 / write_icw3 / write_icw4  out  1 each  one-cycle command strobes
write_ocw1 / write_ocw2 / write_ocw3  out  1 each  one-cycle command strobes
init_done  out  1  high in READY state
cfg_single  out  1  ICW1 bit1 (SNGL)
cfg_icw4  out  1  ICW1 bit0 (IC4)
cfg_level  out  1  ICW1 bit3 (LTIM)
poll_cmd  out  1  one-cycle pulse: OCW3 write with bit2=1
read  out  1  read cycle active
read_select  out  2  00 IRR, 01 ISR, 10 IMR

Behaviour:
- Reset values: internal_data_bus=0; all strobes, poll_cmd, read, init_done, cfg_* = 0; read_select=00; FSM=UNINIT; prev_wr=1.
- Synchronised signals CS_s, RD_s, WR_s, A0_s pass through SYNC_STAGES flops, which reset to 1, 1, 1, 0.
- Latch: on each edge with CS_s=0 and WR_s=0, internal_data_bus←data_bus_in and a0_lat←A0_s. Otherwise both hold.
- Edge detect: prev_wr←1 if CS_s=1, else prev_wr←WR_s. A write completes when prev_wr=0 and WR_s=1.
- Deasserting CS before WR rises forces prev_wr=1, so the write is aborted with no strobe.
- Strobes are registered. They are high for exactly the one cycle after the completion edge, and at most one strobe fires per write.
- Latency: WR pin rise to strobe = SYNC_STAGES+1 falling edges.
- Decode uses a0_lat and internal_data_bus (d):
  - A0=0, d[4]=1 → ICW1, accepted in any state.
  - A0=0, d[4]=0, d[3]=0 → OCW2.
  - A0=0, d[4]=0, d[3]=1 → OCW3.
  - A0=1 → ICW2/ICW3/ICW4/OCW1, selected by FSM state.
- FSM states UNINIT, EXP_ICW2, EXP_ICW3, EXP_ICW4, READY:
  - ICW1 (any state): capture cfg_single=d[1], cfg_icw4=d[0], cfg_level=d[3]; read_select←00; → EXP_ICW2; init_done falls.
  - EXP_ICW2, A0=1: write_icw2. Next state is EXP_ICW3 if !cfg_single, else EXP_ICW4 if cfg_icw4, else READY.
  - EXP_ICW3, A0=1: write_icw3. Next state is EXP_ICW4 if cfg_icw4, else READY.
  - EXP_ICW4, A0=1: write_icw4 → READY.
  - READY, A0=1: write_ocw1. OCW2 and OCW3 are accepted only in READY.
  - UNINIT and EXP_*: OCW2/OCW3 writes are ignored (no strobe, state unchanged). In UNINIT, A0=1 writes are ignored.
- OCW3 accepted:
  - d[1]=1 (RR): read_select←{1'b0, d[0]}.
  - d[1]=0: read_select holds.
  - poll_cmd pulses alongside write_ocw3 when d[2]=1.
- Read: read = ~RD_s & ~CS_s & WR_s, registered. Simultaneous RD and WR low makes the write win and forces read=0.
- A0_s=1 during a read overrides the output to read_select=10. It returns to the stored OCW3 selection when A0_s=0.
- Reset asserted mid-write or mid-sequence clears everything immediately. The first WR rise after reset release yields no strobe unless a full WR low→high was observed after release.

Test Plan:
- Single, no ICW4: ICW1 d=0x12, then A0=1 d=0x20 → write_icw1 then write_icw2 (one cycle each); cfg_single=1, cfg_icw4=0; init_done=1 after ICW2; no icw3/icw4 strobe.
- Cascade + ICW4: ICW1 d=0x11, A0=1 writes 0x40, 0x04, 0x01 → strobes icw1, icw2, icw3, icw4 in order; then A0=1 d=0xFF → write_ocw1, internal_data_bus=0xFF.
- OCW3 read select in READY:
  - d=0x0B → read_select=01, and RD low with A0=0 gives read=1.
  - d=0x08 → stays 01.
  - d=0x0A → 00.
  - d=0x0C → poll_cmd pulse, select unchanged.
  - RD low with A0=1 → read_select=10.
- Aborted and ignored writes:
  - WR low, CS raised before WR rises → no strobe.
  - OCW2 d=0x20 during EXP_ICW2 → no strobe, state unchanged.
  - A0=1 write in UNINIT → no strobe.
- Reset mid-sequence: assert reset after ICW2 of the cascade sequence → init_done=0, read_select=00, next A0=1 write ignored.
- Latency and conflict check with SYNC_STAGES=0 and 2:
  - Strobe appears 1 and 3 edges after WR rise respectively.
  - RD and WR both low → read=0.

Source files
------------

// File: rtl/pic_bus_interface.sv
// 8259A-style CPU bus front end: strobe synchroniser, write latch, initialization
// sequencer and OCW3 read-register selection. All state advances on the falling clock edge.
module pic_bus_interface #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  RD,
  input  logic                  WR,
  input  logic                  address,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] internal_data_bus,
  output logic                  write_icw1,
  output logic                  write_icw2,
  output logic                  write_icw3,
  output logic                  write_icw4,
  output logic                  write_ocw1,
  output logic                  write_ocw2,
  output logic                  write_ocw3,
  output logic                  init_done,
  output logic                  cfg_single,
  output logic                  cfg_icw4,
  output logic                  cfg_level,
  output logic                  poll_cmd,
  output logic                  read,
  output logic [1:0]            read_select,
  output logic [2:0]            fsm_state
);

  typedef enum logic [2:0] {
    UNINIT   = 3'd0,
    EXP_ICW2 = 3'd1,
    EXP_ICW3 = 3'd2,
    EXP_ICW4 = 3'd3,
    READY    = 3'd4
  } state_t;

  state_t     state;
  logic       cs_s, rd_s, wr_s, a0_s;
  logic       prev_wr;
  logic       a0_lat;
  logic [1:0] ocw3_sel;
  logic [1:0] sel_next;
  logic       wr_done;
  logic       read_now;
  logic       is_icw1, is_ocw2, is_ocw3;

  // Idle values of the synchronisers match an inactive bus so reset release never fakes an edge.
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign cs_s = CS;
      assign rd_s = RD;
      assign wr_s = WR;
      assign a0_s = address;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] cs_q, rd_q, wr_q, a0_q;
      always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
          cs_q <= '1;
          rd_q <= '1;
          wr_q <= '1;
          a0_q <= '0;
        end else begin
          cs_q[0] <= CS;
          rd_q[0] <= RD;
          wr_q[0] <= WR;
          a0_q[0] <= address;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            cs_q[i] <= cs_q[i-1];
            rd_q[i] <= rd_q[i-1];
            wr_q[i] <= wr_q[i-1];
            a0_q[i] <= a0_q[i-1];
          end
        end
      end
      assign cs_s = cs_q[SYNC_STAGES-1];
      assign rd_s = rd_q[SYNC_STAGES-1];
      assign wr_s = wr_q[SYNC_STAGES-1];
      assign a0_s = a0_q[SYNC_STAGES-1];
    end
  endgenerate

  assign wr_done   = ~prev_wr & wr_s;
  assign read_now  = ~rd_s & ~cs_s & wr_s;
  assign is_icw1   = ~a0_lat & internal_data_bus[4];
  assign is_ocw2   = ~a0_lat & ~internal_data_bus[4] & ~internal_data_bus[3];
  assign is_ocw3   = ~a0_lat & ~internal_data_bus[4] & internal_data_bus[3];
  assign fsm_state = state;

  always_comb begin
    sel_next = ocw3_sel;
    if (wr_done) begin
      if (is_icw1)
        sel_next = 2'b00;
      else if (is_ocw3 && state == READY && internal_data_bus[1])
        sel_next = {1'b0, internal_data_bus[0]};
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state             <= UNINIT;
      internal_data_bus <= '0;
      a0_lat            <= 1'b0;
      prev_wr           <= 1'b1;
      write_icw1        <= 1'b0;
      write_icw2        <= 1'b0;
      write_icw3        <= 1'b0;
      write_icw4        <= 1'b0;
      write_ocw1        <= 1'b0;
      write_ocw2        <= 1'b0;
      write_ocw3        <= 1'b0;
      poll_cmd          <= 1'b0;
      init_done         <= 1'b0;
      cfg_single        <= 1'b0;
      cfg_icw4          <= 1'b0;
      cfg_level         <= 1'b0;
      read              <= 1'b0;
      ocw3_sel          <= 2'b00;
      read_select       <= 2'b00;
    end else begin
      write_icw1 <= 1'b0;
      write_icw2 <= 1'b0;
      write_icw3 <= 1'b0;
      write_icw4 <= 1'b0;
      write_ocw1 <= 1'b0;
      write_ocw2 <= 1'b0;
      write_ocw3 <= 1'b0;
      poll_cmd   <= 1'b0;

      if (!cs_s && !wr_s) begin
        internal_data_bus <= data_bus_in;
        a0_lat            <= a0_s;
      end
      // Dropping CS mid-write forgets the low phase, so the later WR rise is not a completion.
      prev_wr <= cs_s ? 1'b1 : wr_s;

      if (wr_done) begin
        if (is_icw1) begin
          write_icw1 <= 1'b1;
          cfg_single <= internal_data_bus[1];
          cfg_icw4   <= internal_data_bus[0];
          cfg_level  <= internal_data_bus[3];
          init_done  <= 1'b0;
          state      <= EXP_ICW2;
        end else if (a0_lat) begin
          case (state)
            EXP_ICW2: begin
              write_icw2 <= 1'b1;
              if (!cfg_single)
                state <= EXP_ICW3;
              else if (cfg_icw4)
                state <= EXP_ICW4;
              else begin
                state     <= READY;
                init_done <= 1'b1;
              end
            end
            EXP_ICW3: begin
              write_icw3 <= 1'b1;
              if (cfg_icw4)
                state <= EXP_ICW4;
              else begin
                state     <= READY;
                init_done <= 1'b1;
              end
            end
            EXP_ICW4: begin
              write_icw4 <= 1'b1;
              state      <= READY;
              init_done  <= 1'b1;
            end
            READY:   write_ocw1 <= 1'b1;
            default: ;
          endcase
        end else if (state == READY) begin
          if (is_ocw2)
            write_ocw2 <= 1'b1;
          else if (is_ocw3) begin
            write_ocw3 <= 1'b1;
            poll_cmd   <= internal_data_bus[2];
          end
        end
      end

      ocw3_sel    <= sel_next;
      read        <= read_now;
      read_select <= (read_now && a0_s) ? 2'b10 : sel_next;
    end
  end

endmodule
